// File: rtl/frame_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_mem_arbiter_if                                                 |
// | CPU / VGA request ports and frame RAM port of the frame arbiter.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface frame_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_miss;
    logic              miss_clr;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  vga_req, vga_addr, miss_clr,
        output vga_gnt, vga_rvalid, vga_rdata, vga_miss,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters and RAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output vga_req, vga_addr, miss_clr,
        input  vga_gnt, vga_rvalid, vga_rdata, vga_miss,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/frame_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_mem_arbiter                                                    |
// | VGA-priority single-port frame RAM arbiter with CPU starvation bound.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module frame_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  wire                clk,
    input  wire                reset,
    frame_mem_arbiter_if.slave bus
);
    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [3:0]        r_starve_cnt;
    logic              r_pending;
    logic              r_owner;
    logic              r_vga_miss;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_vga_rdata;

    logic              w_force_cpu;
    logic              w_cpu_gnt;
    logic              w_vga_gnt;
    logic              w_read;
    logic              w_cpu_rvalid;
    logic              w_vga_rvalid;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    // The CPU wins a contended cycle only once it has been denied STARVE_MAX times
    assign w_force_cpu = bus.cpu_req & bus.vga_req & (r_starve_cnt == c_starve_max);
    assign w_cpu_gnt   = reset & bus.cpu_req & (~bus.vga_req | w_force_cpu);
    assign w_vga_gnt   = reset & bus.vga_req & ~w_force_cpu;
    assign w_read      = w_vga_gnt | (w_cpu_gnt & ~bus.cpu_we);

    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_cpu_gnt) begin
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
        end else if (w_vga_gnt) begin
            w_mem_addr  = bus.vga_addr;
        end
    end

    assign bus.cpu_gnt   = w_cpu_gnt;
    assign bus.vga_gnt   = w_vga_gnt;
    assign bus.mem_en    = w_cpu_gnt | w_vga_gnt;
    assign bus.mem_we    = w_cpu_gnt & bus.cpu_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    // RAM data arrives one cycle after the grant; owner 1 = CPU, 0 = VGA
    assign w_cpu_rvalid  = r_pending & r_owner;
    assign w_vga_rvalid  = r_pending & ~r_owner;
    assign bus.cpu_rvalid = w_cpu_rvalid;
    assign bus.vga_rvalid = w_vga_rvalid;
    assign bus.cpu_rdata  = w_cpu_rvalid ? bus.mem_rdata : r_cpu_rdata;
    assign bus.vga_rdata  = w_vga_rvalid ? bus.mem_rdata : r_vga_rdata;
    assign bus.vga_miss   = r_vga_miss;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
            r_pending    <= 1'b0;
            r_owner      <= 1'b0;
            r_vga_miss   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_vga_rdata  <= '0;
        end else begin
            if (!bus.cpu_req || w_cpu_gnt) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != c_starve_max) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            r_pending <= w_read;
            if (w_read) begin
                r_owner <= w_cpu_gnt;
            end

            if (w_cpu_rvalid) begin
                r_cpu_rdata <= bus.mem_rdata;
            end
            if (w_vga_rvalid) begin
                r_vga_rdata <= bus.mem_rdata;
            end

            // A new miss takes precedence over a simultaneous clear
            if (w_cpu_gnt & bus.vga_req) begin
                r_vga_miss <= 1'b1;
            end else if (bus.miss_clr) begin
                r_vga_miss <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire
